sdram_cmd_arbiter: RTL and testbench
====================================

Name: sdram_cmd_arbiter

Overview:
- Shares the single SDRAM command port (cmd/addr/data) between NUM_REQ write requesters using round-robin arbitration.
- Enforces a minimum idle gap after every command.
- Inserts periodic refresh windows during which no command is issued.
- Sits between client DMA/agent ports and the sdram_ifc bundle; drives its cmd, addr and data fields.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_SZ_P, 32, data width.
- ADDR_SZ_P, 10, address width.
- GAP_CYCLES, 1, idle cycles forced after each issued command (0 allows back-to-back).
- REFRESH_PERIOD, 64, cycles between refresh requests; must exceed REFRESH_CYCLES+GAP_CYCLES+1.
- REFRESH_CYCLES, 4, length of a refresh window in cycles (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready.
- req_addr  in  NUM_REQ*ADDR_SZ_P  packed addresses; requester i occupies slice i.
- req_data  in  NUM_REQ*DATA_SZ_P  packed write data.
- cmd  out  1  1 = write command this cycle, 0 = idle.
- addr  out  ADDR_SZ_P  command address.
- data  out  DATA_SZ_P  command data.
- grant_id  out  $clog2(NUM_REQ)  index of the requester whose command is on cmd.
- busy  out  1  high when state≠IDLE or cmd=1.

Behaviour:
- Reset (reset=0 at a clk edge):
  - cmd, addr, data, grant_id and busy = 0.
  - state = IDLE; gap counter and refresh counter = 0; refresh_pending = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has priority first.
  - req_ready = 0 while reset is low.
  - Reset asserted mid-GAP or mid-REFRESH aborts the window immediately.
- Refresh counter:
  - Free-running 0..REFRESH_PERIOD-1, then wraps.
  - At the wrap, refresh_pending is set.
  - refresh_pending is cleared on entry to REFRESH.
- States: IDLE, GAP, REFRESH.
- IDLE:
  - If refresh_pending: go to REFRESH with the window counter loaded to REFRESH_CYCLES. req_ready = 0 this cycle. Refresh beats requests when both arrive together.
  - Otherwise, if any req_valid: the round-robin winner w gets req_ready[w] = 1 combinationally in the same cycle.
    - Winner search starts at pointer+1, modulo NUM_REQ.
    - At the edge: cmd←1, addr←req_addr[w], data←req_data[w], grant_id←w, pointer←w.
    - Next state is GAP with the counter loaded to GAP_CYCLES, or IDLE if GAP_CYCLES = 0.
  - Otherwise stay in IDLE with cmd←0.
- GAP:
  - cmd←0 and req_ready = 0.
  - Counter decrements each cycle; at 1, go to IDLE.
- REFRESH:
  - cmd←0 and req_ready = 0 for exactly REFRESH_CYCLES cycles, then IDLE.
- Latency and output holding:
  - Accept to cmd=1 is 1 cycle.
  - cmd is high for exactly one cycle per accepted request.
  - addr, data and grant_id hold their last values while cmd = 0.
- Requester side:
  - req_ready is never asserted to a requester with req_valid = 0; req_ready is at most one-hot.
  - Requesters must hold addr/data stable while valid and not ready.
  - A requester that deasserts valid before ready loses its turn, with no side effect.
  - The RR pointer advances only on an accept.
- Throughput: with all valid and GAP_CYCLES = G, one command every G+1 cycles, excluding refresh windows.

Decomposition:
- Package sdram_pkg holds:
  - state enum sdram_arb_state_t {IDLE, GAP, REFRESH};
  - CMD_IDLE = 1'b0 and CMD_WRITE = 1'b1;
  - the grant-index width function.
- Sub-module sdram_rr_arbiter:
  - combinational winner/one-hot grant from req_valid and the pointer;
  - pointer register updated on an accept strobe.
- The FSM, counters and output registers stay in the top block.

Test Plan (NUM_REQ=4, GAP_CYCLES=1, REFRESH_PERIOD=64, REFRESH_CYCLES=4 unless stated):
- Reset hygiene: reset=0 for 3 cycles with req_valid=4'b1111 → req_ready=0 and cmd=0 throughout. In the first cycle after release, req_ready=4'b0001; next cycle cmd=1 with addr=req_addr[0] and grant_id=0.
- Single requester: only req2 valid, addr 0x3A0, data 0xDEADBEEF → req_ready=4'b0100 at t; at t+1 cmd=1, addr=0x3A0, data=0xDEADBEEF, grant_id=2; at t+2 cmd=0; addr and data held.
- Fairness: all four valid continuously → grant_id sequence 0,1,2,3,0,1; cmd pattern 1,0,1,0…; each requester accepted once per 8 cycles.
- Refresh collision: requests pending when the refresh counter wraps → next IDLE enters REFRESH. req_ready=0, cmd=0, busy=1 for 4 cycles, then grant resumes with the requester next in RR order.
- Reset mid-operation: reset=0 during GAP and again during REFRESH → after release all outputs are 0, the refresh window is abandoned, the refresh counter restarts, and requester 0 wins first.
- Back-to-back: GAP_CYCLES=0, req0 and req1 valid → cmd=1 every cycle; grant_id alternates 0,1,0,1 until refresh.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types, command codes and helpers for the SDRAM command arbiter
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GAP     = 2'd1,
        REFRESH = 2'd2
    } sdram_arb_state_t;

    localparam logic CMD_IDLE  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - round-robin winner select with a pointer that moves only on accept
module sdram_rr_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic                         accept,
    output logic [NUM_REQ-1:0]           grant,
    output logic [grant_w(NUM_REQ)-1:0]  grant_idx,
    output logic                         grant_any
);

    localparam int GW = grant_w(NUM_REQ);

    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;

    // Search begins one past the last winner so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        grant_any = 1'b0;
        if (enable) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                if (!grant_any && req_valid[(int'(ptr_q) + off) % NUM_REQ]) begin
                    grant_any = 1'b1;
                    grant_idx = GW'((int'(ptr_q) + off) % NUM_REQ);
                    grant[(int'(ptr_q) + off) % NUM_REQ] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= GW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - shares one SDRAM write command port with idle gaps and periodic refresh
module sdram_cmd_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_SZ_P      = 32,
    parameter int ADDR_SZ_P      = 10,
    parameter int GAP_CYCLES     = 1,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_SZ_P-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SZ_P-1:0]   req_data,
    output logic                           cmd,
    output logic [ADDR_SZ_P-1:0]           addr,
    output logic [DATA_SZ_P-1:0]           data,
    output logic [grant_w(NUM_REQ)-1:0]    grant_id,
    output logic                           busy
);

    localparam int GW    = grant_w(NUM_REQ);
    localparam int MAXC  = (GAP_CYCLES > REFRESH_CYCLES) ? GAP_CYCLES : REFRESH_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    sdram_arb_state_t state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REF_W-1:0]     ref_cnt_q, ref_cnt_d;
    logic                 ref_pend_q, ref_pend_d;
    logic                 cmd_q, cmd_d;
    logic [ADDR_SZ_P-1:0] addr_q, addr_d;
    logic [DATA_SZ_P-1:0] data_q, data_d;
    logic [GW-1:0]        grant_q, grant_d;

    logic                 arb_en;
    logic [NUM_REQ-1:0]   win_grant;
    logic [GW-1:0]        win_idx;
    logic                 win_any;
    logic                 ref_wrap;

    // A pending refresh blocks new grants, so refresh wins a same-cycle collision.
    assign arb_en = reset && (state_q == IDLE) && !ref_pend_q;

    sdram_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .enable    (arb_en),
        .req_valid (req_valid),
        .accept    (win_any),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign ref_wrap = (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
        ref_pend_d = ref_pend_q;
        cmd_d      = CMD_IDLE;
        addr_d     = addr_q;
        data_d     = data_q;
        grant_d    = grant_q;
        case (state_q)
            IDLE: begin
                if (ref_pend_q) begin
                    state_d    = REFRESH;
                    cnt_d      = CNT_W'(REFRESH_CYCLES);
                    ref_pend_d = 1'b0;
                end else if (win_any) begin
                    cmd_d   = CMD_WRITE;
                    addr_d  = req_addr[int'(win_idx)*ADDR_SZ_P +: ADDR_SZ_P];
                    data_d  = req_data[int'(win_idx)*DATA_SZ_P +: DATA_SZ_P];
                    grant_d = win_idx;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES);
                end
            end
            GAP, REFRESH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ref_wrap) begin
            ref_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            cmd_q      <= CMD_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
        end
    end

    assign req_ready = win_grant;
    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign data      = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE) || (cmd_q == CMD_WRITE);

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb/tb_sdram_cmd_arbiter.sv - randomized bench for sdram_cmd_arbiter against a timestamp-based model
module tb_sdram_cmd_arbiter;

    localparam int N    = 4;
    localparam int A    = 10;
    localparam int D    = 32;
    localparam int P    = 64;
    localparam int R    = 4;
    localparam int NCYC = 420;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   v      [2];
    logic [N*A-1:0] a      [2];
    logic [N*D-1:0] d      [2];
    logic [N-1:0]   rdy    [2];
    logic           cmd_o  [2];
    logic [A-1:0]   addr_o [2];
    logic [D-1:0]   data_o [2];
    logic [1:0]     gid_o  [2];
    logic           busy_o [2];

    sdram_cmd_arbiter #(
        .NUM_REQ(N), .DATA_SZ_P(D), .ADDR_SZ_P(A),
        .GAP_CYCLES(1), .REFRESH_PERIOD(P), .REFRESH_CYCLES(R)
    ) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(v[0]), .req_ready(rdy[0]), .req_addr(a[0]), .req_data(d[0]),
        .cmd(cmd_o[0]), .addr(addr_o[0]), .data(data_o[0]), .grant_id(gid_o[0]), .busy(busy_o[0])
    );

    sdram_cmd_arbiter #(
        .NUM_REQ(N), .DATA_SZ_P(D), .ADDR_SZ_P(A),
        .GAP_CYCLES(0), .REFRESH_PERIOD(P), .REFRESH_CYCLES(R)
    ) dut_b2b (
        .clk(clk), .reset(rst_n),
        .req_valid(v[1]), .req_ready(rdy[1]), .req_addr(a[1]), .req_data(d[1]),
        .cmd(cmd_o[1]), .addr(addr_o[1]), .data(data_o[1]), .grant_id(gid_o[1]), .busy(busy_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: cycle index since reset, the cycle at which the port is free again, and the last winner.
    int           m_cyc  [2];
    int           m_free [2];
    int           m_last [2];
    bit           m_pend [2];
    bit           m_inref[2];
    logic         e_cmd  [2];
    logic [A-1:0] e_addr [2];
    logic [D-1:0] e_data [2];
    logic [1:0]   e_gid  [2];
    logic         e_busy [2];
    logic [N-1:0] e_rdy  [2];

    task automatic model_reset(input int m);
        m_cyc[m]   = 0;
        m_free[m]  = 0;
        m_last[m]  = N - 1;
        m_pend[m]  = 1'b0;
        m_inref[m] = 1'b0;
        e_cmd[m]   = 1'b0;
        e_addr[m]  = '0;
        e_data[m]  = '0;
        e_gid[m]   = '0;
        e_busy[m]  = 1'b0;
    endtask

    task automatic model_cycle(input int m);
        int  g;
        int  w;
        bit  fire;
        g    = (m == 0) ? 1 : 0;
        fire = 1'b0;
        e_rdy[m] = '0;
        if (!rst_n) begin
            model_reset(m);
        end else begin
            if (m_cyc[m] >= m_free[m]) begin
                if (m_pend[m]) begin
                    m_pend[m]  = 1'b0;
                    m_inref[m] = 1'b1;
                    m_free[m]  = m_cyc[m] + 1 + R;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        w = (m_last[m] + k) % N;
                        if (!fire && v[m][w]) begin
                            fire        = 1'b1;
                            e_rdy[m][w] = 1'b1;
                            m_last[m]   = w;
                            e_addr[m]   = a[m][w*A +: A];
                            e_data[m]   = d[m][w*D +: D];
                            e_gid[m]    = 2'(w);
                            m_free[m]   = m_cyc[m] + 1 + g;
                            m_inref[m]  = 1'b0;
                        end
                    end
                end
            end
            if (m_cyc[m] % P == P - 1) m_pend[m] = 1'b1;
            e_cmd[m]  = fire;
            e_busy[m] = fire || (m_cyc[m] + 1 < m_free[m]);
            m_cyc[m]++;
        end
    endtask

    initial begin
        int  rst_left;
        int  dens;
        bit  did_gap;
        bit  did_ref;
        bit  all_phase;
        rst_left = 2;
        did_gap  = 1'b0;
        did_ref  = 1'b0;
        rst_n    = 1'b0;
        for (int m = 0; m < 2; m++) begin
            v[m] = '1;
            for (int i = 0; i < N; i++) begin
                a[m][i*A +: A] = A'($urandom);
                d[m][i*D +: D] = $urandom;
            end
            model_reset(m);
            e_rdy[m] = '0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                check($sformatf("cmd[%0d]@%0d", m, c), 64'(cmd_o[m]), 64'(e_cmd[m]));
                check($sformatf("addr[%0d]@%0d", m, c), 64'(addr_o[m]), 64'(e_addr[m]));
                check($sformatf("data[%0d]@%0d", m, c), 64'(data_o[m]), 64'(e_data[m]));
                check($sformatf("grant_id[%0d]@%0d", m, c), 64'(gid_o[m]), 64'(e_gid[m]));
                check($sformatf("busy[%0d]@%0d", m, c), 64'(busy_o[m]), 64'(e_busy[m]));
            end

            if (rst_left > 0) begin
                rst_n = 1'b0;
                rst_left--;
            end else begin
                rst_n = 1'b1;
            end
            if (rst_n && !did_gap && c > 100 && m_cyc[0] < m_free[0] && !m_inref[0]) begin
                rst_n    = 1'b0;
                rst_left = 1;
                did_gap  = 1'b1;
            end
            if (rst_n && !did_ref && c > 150 && m_inref[0] && m_cyc[0] + 1 < m_free[0]) begin
                rst_n    = 1'b0;
                rst_left = 1;
                did_ref  = 1'b1;
            end

            all_phase = (c < 60);
            dens = (c < 200) ? 30 : (c < 300) ? 90 : 60;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    if (v[m][i] && !e_rdy[m][i] && (all_phase || $urandom_range(7) != 0)) begin
                        v[m][i] = 1'b1;
                    end else begin
                        v[m][i] = all_phase ? 1'b1 : ($urandom_range(99) < dens);
                        a[m][i*A +: A] = A'($urandom);
                        d[m][i*D +: D] = $urandom;
                    end
                end
            end

            #1;
            for (int m = 0; m < 2; m++) begin
                model_cycle(m);
                check($sformatf("req_ready[%0d]@%0d", m, c), 64'(rdy[m]), 64'(e_rdy[m]));
            end
        end
        check("reset_in_gap_exercised", 64'(did_gap), 64'd1);
        check("reset_in_refresh_exercised", 64'(did_ref), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
